// File: rtl/mmio_gpio_pwm_if.sv
// Load/store port between the core, this peripheral and data memory.
interface mmio_gpio_pwm_if;
   logic        write_mem;
   logic        read_mem;
   logic [31:0] data_address;
   logic [31:0] data_to_write;
   logic [31:0] data_from_mem;
   logic [31:0] data_read;

   modport master (
      output write_mem, read_mem, data_address, data_to_write, data_from_mem,
      input  data_read
   );

   modport slave (
      input  write_mem, read_mem, data_address, data_to_write, data_from_mem,
      output data_read
   );
endinterface

// File: rtl/mmio_gpio_pwm.sv
// GPIO with synchronised inputs, rising-edge flags and interrupt, plus NUM_PWM
// PWM channels sharing one prescaled counter, in a 64-byte window on the data bus.
module mmio_gpio_pwm #(
   parameter int unsigned GPIO_WIDTH = 32,
   parameter int unsigned NUM_PWM    = 4,
   parameter int unsigned PWM_WIDTH  = 8,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFC0
) (
   input  logic                  clk,
   input  logic                  rst,
   mmio_gpio_pwm_if.slave        bus,
   input  logic [GPIO_WIDTH-1:0] IO_in,
   output logic [GPIO_WIDTH-1:0] IO_out,
   output logic [GPIO_WIDTH-1:0] IO_oe,
   output logic [NUM_PWM-1:0]    pwm_out,
   output logic                  irq
);

   typedef enum logic [3:0] {
      REG_OUT      = 4'd0,
      REG_IN       = 4'd1,
      REG_OE       = 4'd2,
      REG_EDGE     = 4'd3,
      REG_MASK     = 4'd4,
      REG_PRESCALE = 4'd5,
      REG_PWM_EN   = 4'd6,
      REG_CNT      = 4'd7
   } reg_e;

   logic [GPIO_WIDTH-1:0] r_out, r_oe, r_edge, r_mask;
   logic [GPIO_WIDTH-1:0] r_sync1, r_sync, r_sync_d;
   logic [15:0]           r_prescale, r_pre;
   logic [NUM_PWM-1:0]    r_pwm_en, r_pwm_out;
   logic [PWM_WIDTH-1:0]  r_cnt;
   logic [NUM_PWM-1:0][PWM_WIDTH-1:0] r_duty_sh, r_duty_act;
   logic                  r_irq;

   logic                  w_hit, w_aligned, w_wr, w_tick, w_wrap;
   logic [3:0]            w_idx;
   logic [31:0]           w_rdata;
   logic [GPIO_WIDTH-1:0] w_rise;

   assign w_hit     = (bus.data_address[31:6] == BASE_ADDR[31:6]);
   assign w_aligned = (bus.data_address[1:0] == 2'b00);
   assign w_idx     = bus.data_address[5:2];
   assign w_wr      = bus.write_mem && w_hit && w_aligned;
   assign w_rise    = r_sync & ~r_sync_d;
   assign w_tick    = (r_pre == r_prescale);
   assign w_wrap    = w_tick && (r_cnt == '1);

   always_comb begin
      w_rdata = '0;
      if (w_aligned) begin
         case (w_idx)
            REG_OUT:      w_rdata = 32'(r_out);
            REG_IN:       w_rdata = 32'(r_sync);
            REG_OE:       w_rdata = 32'(r_oe);
            REG_EDGE:     w_rdata = 32'(r_edge);
            REG_MASK:     w_rdata = 32'(r_mask);
            REG_PRESCALE: w_rdata = 32'(r_prescale);
            REG_PWM_EN:   w_rdata = 32'(r_pwm_en);
            REG_CNT:      w_rdata = 32'(r_cnt);
            default: begin
               for (int unsigned i = 0; i < NUM_PWM; i++)
                  if (w_idx == 4'(8 + i)) w_rdata = 32'(r_duty_sh[i]);
            end
         endcase
      end
   end

   // Reads see register state before any same-cycle write.
   assign bus.data_read = (bus.read_mem && w_hit) ? w_rdata : bus.data_from_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out      <= '0;
         r_oe       <= '0;
         r_mask     <= '0;
         r_prescale <= '0;
         r_pwm_en   <= '0;
      end else if (w_wr) begin
         case (w_idx)
            REG_OUT:      r_out      <= bus.data_to_write[GPIO_WIDTH-1:0];
            REG_OE:       r_oe       <= bus.data_to_write[GPIO_WIDTH-1:0];
            REG_MASK:     r_mask     <= bus.data_to_write[GPIO_WIDTH-1:0];
            REG_PRESCALE: r_prescale <= bus.data_to_write[15:0];
            REG_PWM_EN:   r_pwm_en   <= bus.data_to_write[NUM_PWM-1:0];
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync   <= '0;
         r_sync_d <= '0;
         r_edge   <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_sync1  <= IO_in;
         r_sync   <= r_sync1;
         r_sync_d <= r_sync;
         // A new edge overrides a simultaneous write-1-to-clear.
         if (w_wr && w_idx == REG_EDGE)
            r_edge <= (r_edge & ~bus.data_to_write[GPIO_WIDTH-1:0]) | w_rise;
         else
            r_edge <= r_edge | w_rise;
         r_irq <= |(r_edge & r_mask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else begin
         // Shrinking PRESCALE below pre restarts the count without a tick.
         if (w_tick || (r_pre > r_prescale)) r_pre <= '0;
         else                                r_pre <= r_pre + 16'd1;
         if (w_tick) r_cnt <= r_cnt + PWM_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_duty_sh  <= '0;
         r_duty_act <= '0;
         r_pwm_out  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PWM; i++) begin
            if (w_wr && w_idx == 4'(8 + i))
               r_duty_sh[i] <= bus.data_to_write[PWM_WIDTH-1:0];
            if (w_wrap || !r_pwm_en[i])
               r_duty_act[i] <= r_duty_sh[i];
            r_pwm_out[i] <= r_pwm_en[i] && (r_cnt < r_duty_act[i]);
         end
      end
   end

   assign IO_out  = r_out;
   assign IO_oe   = r_oe;
   assign pwm_out = r_pwm_out;
   assign irq     = r_irq;

endmodule

// File: tb/tb_mmio_gpio_pwm.sv
// Directed bench for mmio_gpio_pwm: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_mmio_gpio_pwm;

   localparam logic [31:0] BASE = 32'hFFFF_FFC0;
   localparam logic [31:0] MEMD = 32'h1234_5678;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IO_in, IO_out, IO_oe;
   logic [3:0]  pwm_out;
   logic        irq;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   mmio_gpio_pwm_if bus ();

   mmio_gpio_pwm #(
      .GPIO_WIDTH (32),
      .NUM_PWM    (4),
      .PWM_WIDTH  (8),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .IO_in   (IO_in),
      .IO_out  (IO_out),
      .IO_oe   (IO_oe),
      .pwm_out (pwm_out),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t x;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: observed %h expected <queued value>", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic pin(input string tag, input logic [31:0] obs, input logic [31:0] e);
      push(tag, e);
      check(obs);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.data_address  = a;
      bus.data_to_write = d;
      bus.write_mem     = 1'b1;
      @(negedge clk);
      bus.write_mem     = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
      push(tag, e);
      bus.data_address = a;
      bus.read_mem     = 1'b1;
      #1;
      check(bus.data_read);
      bus.read_mem     = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] v);
      bus.data_address = a;
      bus.read_mem     = 1'b1;
      #1;
      v = bus.data_read;
      bus.read_mem     = 1'b0;
   endtask

   task automatic count_hi(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(pwm_out[0]);
      end
   endtask

   initial begin
      logic [31:0] v;
      int          hi;
      bit          found;

      rst               = 1'b1;
      IO_in             = '0;
      bus.write_mem     = 1'b0;
      bus.read_mem      = 1'b0;
      bus.data_address  = '0;
      bus.data_to_write = '0;
      bus.data_from_mem = MEMD;
      repeat (2) @(negedge clk);
      pin("rst_io_out", IO_out, 32'h0);
      pin("rst_io_oe", IO_oe, 32'h0);
      pin("rst_pwm", 32'(pwm_out), 32'h0);
      pin("rst_irq", 32'(irq), 32'h0);
      rst = 1'b0;

      // register access
      wr(BASE + 32'h00, 32'hA5A5_0F0F);
      pin("io_out", IO_out, 32'hA5A5_0F0F);
      wr(BASE + 32'h08, 32'hFFFF_0000);
      pin("io_oe", IO_oe, 32'hFFFF_0000);
      rd(BASE + 32'h00, 32'hA5A5_0F0F, "rd_out");
      rd(32'h0000_0100, MEMD, "rd_passthru");
      rd(BASE + 32'h01, 32'h0, "rd_misaligned");
      rd(BASE + 32'h3C, 32'h0, "rd_unmapped");
      wr(BASE + 32'h01, 32'h0);
      rd(BASE + 32'h00, 32'hA5A5_0F0F, "wr_misaligned_ignored");

      push("rw_old_value", 32'hA5A5_0F0F);
      bus.data_address  = BASE;
      bus.data_to_write = 32'h1111_2222;
      bus.read_mem      = 1'b1;
      bus.write_mem     = 1'b1;
      #1;
      check(bus.data_read);
      @(negedge clk);
      bus.read_mem  = 1'b0;
      bus.write_mem = 1'b0;
      pin("rw_new_value", IO_out, 32'h1111_2222);

      // input synchroniser, edge capture, interrupt
      IO_in[3] = 1'b1;
      @(negedge clk);
      rd(BASE + 32'h04, 32'h0, "in_after_1_edge");
      @(negedge clk);
      rd(BASE + 32'h04, 32'h8, "in_after_2_edges");
      rd(BASE + 32'h0C, 32'h0, "edge_after_2_edges");
      @(negedge clk);
      rd(BASE + 32'h0C, 32'h8, "edge_after_3_edges");
      pin("irq_unmasked_off", 32'(irq), 32'h0);
      wr(BASE + 32'h10, 32'h8);
      pin("irq_lag", 32'(irq), 32'h0);
      @(negedge clk);
      pin("irq_set", 32'(irq), 32'h1);
      wr(BASE + 32'h0C, 32'h8);
      rd(BASE + 32'h0C, 32'h0, "edge_w1c");
      @(negedge clk);
      pin("irq_clear", 32'(irq), 32'h0);

      IO_in[3] = 1'b0;
      repeat (4) @(negedge clk);
      IO_in[3] = 1'b1;
      repeat (2) @(negedge clk);
      wr(BASE + 32'h0C, 32'h8);
      rd(BASE + 32'h0C, 32'h8, "edge_set_beats_w1c");
      wr(BASE + 32'h0C, 32'h8);
      wr(BASE + 32'h10, 32'h0);

      // PWM, prescale 0
      wr(BASE + 32'h20, 32'hFFFF_FF40);
      wr(BASE + 32'h18, 32'hFFFF_FFFF);
      rd(BASE + 32'h18, 32'hF, "pwm_en_width");
      rd(BASE + 32'h20, 32'h40, "duty_width");
      count_hi(256, hi);
      pin("pwm_duty64", 32'(hi), 32'd64);

      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         peek(BASE + 32'h1C, v);
         if (v == 32'd99) found = 1'b1;
         else @(negedge clk);
      end
      pin("sync_cnt99", v, 32'd99);
      wr(BASE + 32'h20, 32'd200);
      count_hi(156, hi);
      pin("pwm_current_period", 32'(hi), 32'd0);
      count_hi(256, hi);
      pin("pwm_next_period", 32'(hi), 32'd200);

      wr(BASE + 32'h20, 32'd255);
      repeat (300) @(negedge clk);
      count_hi(256, hi);
      pin("pwm_duty255", 32'(hi), 32'd255);
      wr(BASE + 32'h18, 32'h0);
      @(negedge clk);
      pin("pwm_disable_low", 32'(pwm_out), 32'h0);
      wr(BASE + 32'h20, 32'd0);
      wr(BASE + 32'h18, 32'h1);
      count_hi(256, hi);
      pin("pwm_duty0", 32'(hi), 32'd0);

      // asynchronous reset mid-period
      wr(BASE + 32'h20, 32'd255);
      wr(BASE + 32'h10, 32'hFFFF_FFFF);
      repeat (300) @(negedge clk);
      rst = 1'b1;
      #1;
      pin("midrst_io_out", IO_out, 32'h0);
      pin("midrst_io_oe", IO_oe, 32'h0);
      pin("midrst_pwm", 32'(pwm_out), 32'h0);
      pin("midrst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      IO_in = '0;
      rst   = 1'b0;
      rd(BASE + 32'h1C, 32'h0, "cnt_after_reset");
      rd(BASE + 32'h18, 32'h0, "en_after_reset");
      rd(BASE + 32'h20, 32'h0, "duty_after_reset");

      // prescaler
      wr(BASE + 32'h14, 32'd3);
      rd(BASE + 32'h1C, 32'd1, "cnt_first_tick");
      repeat (3) @(negedge clk);
      rd(BASE + 32'h1C, 32'd1, "cnt_hold_3");
      @(negedge clk);
      rd(BASE + 32'h1C, 32'd2, "cnt_step_4");
      repeat (2) @(negedge clk);
      wr(BASE + 32'h14, 32'hFFFF_0001);
      rd(BASE + 32'h14, 32'd1, "prescale_width");
      @(negedge clk);
      rd(BASE + 32'h1C, 32'd2, "prescale_shrink_no_tick");
      @(negedge clk);
      rd(BASE + 32'h1C, 32'd2, "prescale_restart");
      @(negedge clk);
      rd(BASE + 32'h1C, 32'd3, "prescale_new_tick");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_gpio_pwm.md
# mmio_gpio_pwm

Parametrised memory-mapped I/O peripheral for the RV32 core's data-memory path: GPIO output/direction registers, synchronised inputs with rising-edge capture and interrupt, and `NUM_PWM` glitch-free PWM channels sharing a prescaled counter. It sits between the core's load/store port and data memory. It claims a 64-byte window at `BASE_ADDR`, returns its own read data for window hits and passes `data_from_mem` through for all other addresses.

## Interface
- `GPIO_WIDTH`, 32: number of GPIO pins, 1..32.
- `NUM_PWM`, 4: PWM channel count, 1..8.
- `PWM_WIDTH`, 8: PWM counter/duty width, 2..16.
- `BASE_ADDR`, 32'hFFFF_FFC0: window base, 64-byte aligned.
- Reset is `rst`, asynchronous, active-high. The clock is `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  async active-high reset
- `write_mem`  in  1  store strobe, one cycle per access
- `read_mem`  in  1  load strobe
- `data_address`  in  32  byte address
- `data_to_write`  in  32  store data
- `data_from_mem`  in  32  data-memory read data
- `data_read`  out  32  read data to core
- `IO_in`  in  GPIO_WIDTH  asynchronous input pins
- `IO_out`  out  GPIO_WIDTH  output register
- `IO_oe`  out  GPIO_WIDTH  per-pin output enable (1 = drive)
- `pwm_out`  out  NUM_PWM  PWM outputs
- `irq`  out  1  level interrupt

## Operation
- A window hit is `data_address[31:6] == BASE_ADDR[31:6]`. The offset is `data_address[5:0]` and must be word-aligned; offsets with bits [1:0] ≠ 0 are unmapped.
- Register map, all fields right-justified and upper bits read 0:
  - 0x00 OUT, RW.
  - 0x04 IN, RO: synchronised pins.
  - 0x08 OE, RW.
  - 0x0C EDGE, W1C: rising-edge flags.
  - 0x10 MASK, RW.
  - 0x14 PRESCALE, RW, 16 bits.
  - 0x18 PWM_EN, RW, NUM_PWM bits.
  - 0x1C CNT, RO: current PWM counter.
  - 0x20+4·i DUTY[i], RW, PWM_WIDTH bits, for i < NUM_PWM.
- Unmapped offsets inside the window read 0 and ignore writes.
- Read path, combinational:
  - If `read_mem` and hit, `data_read` is the register value.
  - Otherwise `data_read = data_from_mem`, including on writes.
- Writes:
  - Take effect only when `write_mem` and hit.
  - If `read_mem` and `write_mem` are both high, the write takes effect and the read returns the pre-write value.
- Inputs:
  - `IO_in` passes through a 2-flop synchroniser to `sync`, plus a third flop `sync_d`.
  - `EDGE[j]` sets when `sync[j] & ~sync_d[j]`.
  - A W1C of bit j clears it unless a new edge on j occurs in the same cycle; the set wins.
- `irq = |(EDGE & MASK)`, registered.
- Prescaler:
  - A 16-bit `pre` counts 0..PRESCALE.
  - `tick` pulses when `pre == PRESCALE`, and `pre` returns to 0 on that cycle.
  - PRESCALE = 0 gives a tick every cycle.
  - Writing PRESCALE below the current `pre` forces `pre` to 0 on the next cycle, which is not a tick.
- PWM counter:
  - `cnt` is PWM_WIDTH bits and increments on `tick`.
  - It wraps from 2^PWM_WIDTH−1 to 0.
  - The period is 2^PWM_WIDTH ticks.
- Per channel:
  - Written DUTY goes to `duty_sh[i]`.
  - `duty_act[i] <= duty_sh[i]` on a wrap tick (`tick && cnt == max`), or on any cycle where `PWM_EN[i] = 0`.
  - `pwm_out[i] <= PWM_EN[i] && (cnt < duty_act[i])`, registered.
  - Duty 0 gives constant low. Duty max gives high for max counts of every 2^PWM_WIDTH.
  - A duty change on an enabled channel never shortens or extends the current period.
- `IO_out = OUT`, `IO_oe = OE`, both direct register outputs.

## Timing
- Reset, asynchronous: OUT, OE, EDGE, MASK, PRESCALE, PWM_EN, DUTY, `duty_act`, `pre`, `cnt`, the synchronisers, `irq` and `pwm_out` are all 0. Outputs `IO_out`, `IO_oe`, `pwm_out` and `irq` are all 0 at reset.
- Reset mid-period aborts the period. After release, counting starts from `pre = 0`, `cnt = 0`.
- Register write at edge N is visible to reads and on `IO_out`/`IO_oe` after edge N.
- An `IO_in` change is readable in IN two edges later.
- EDGE sets 3 edges after the pin rises.
- `irq` follows one edge after the EDGE/MASK change.
- `pwm_out` lags the `cnt` comparison by one cycle.
- Disabling a channel drives its output low one edge later.

## Test plan
- Reset with `IO_in = 0`: write OUT = 0xA5A5_0F0F, OE = 0xFFFF_0000 → `IO_out`/`IO_oe` update the next cycle. A read of 0x00 returns 0xA5A5_0F0F, and a read of 0x100 returns `data_from_mem`.
- `IO_in[3]` goes 0→1: IN bit 3 reads 1 after 2 edges and EDGE = 0x8 after 3 edges. With MASK = 0x8, `irq` = 1 one edge later. A W1C of 0x8 clears `irq`. A W1C in the same cycle as a new edge on bit 3 leaves EDGE = 0x8.
- PWM_WIDTH = 8, PRESCALE = 0, DUTY[0] = 64, EN = 1 → `pwm_out[0]` is high 64 of every 256 cycles. DUTY 0 gives constant low, and DUTY 255 gives 255 high / 1 low.
- Write DUTY[0] = 200 mid-period (`cnt` = 100) → the current period keeps 64 high and the next period has 200 high.
- PRESCALE = 3 → `cnt` advances every 4 cycles. Writing PRESCALE = 1 while `pre` = 3 resets `pre` to 0 with no tick.
- Assert `rst` mid-period → all outputs are 0 immediately. After release with EN = 0, a read of 0x1C returns 0.
